// File: rtl/hamming_pkg.sv
// Purpose : Shared Hamming(7,4) definitions for the UART link.
//           Holds the codeword bit-position map and the syndrome,
//           correction, extraction and encode helpers. The encoder is
//           also used on the transmitter side.
// Ports   : none (package)
package hamming_pkg;

    // Codeword bit positions (Hamming position p = index + 1)
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int D1 = 2;
    localparam int P4 = 3;
    localparam int D2 = 4;
    localparam int D3 = 5;
    localparam int D4 = 6;

    // Syndrome {s4,s2,s1}. A nonzero value is the 1-based position of a single-bit error.
    function automatic logic [2:0] hamming_syndrome(input logic [6:0] cw);
        logic s1;
        logic s2;
        logic s4;
        s1 = cw[P1] ^ cw[D1] ^ cw[D2] ^ cw[D4];
        s2 = cw[P2] ^ cw[D1] ^ cw[D3] ^ cw[D4];
        s4 = cw[P4] ^ cw[D2] ^ cw[D3] ^ cw[D4];
        return {s4, s2, s1};
    endfunction

    // Flip the bit named by the syndrome. A zero syndrome leaves the word untouched.
    function automatic logic [6:0] hamming_correct(input logic [6:0] cw, input logic [2:0] syn);
        logic [6:0] mask;
        if (syn != 3'd0) begin
            mask = 7'd1 << (syn - 3'd1);
        end else begin
            mask = 7'd0;
        end
        return cw ^ mask;
    endfunction

    // Data nibble {d4,d3,d2,d1} from a codeword
    function automatic logic [3:0] hamming_extract(input logic [6:0] cw);
        return {cw[D4], cw[D3], cw[D2], cw[D1]};
    endfunction

    // Build a codeword from nibble {d4,d3,d2,d1}
    function automatic logic [6:0] hamming_encode(input logic [3:0] d);
        logic [6:0] cw;
        cw     = 7'd0;
        cw[D1] = d[0];
        cw[D2] = d[1];
        cw[D3] = d[2];
        cw[D4] = d[3];
        cw[P1] = d[0] ^ d[1] ^ d[3];
        cw[P2] = d[0] ^ d[2] ^ d[3];
        cw[P4] = d[1] ^ d[2] ^ d[3];
        return cw;
    endfunction

endpackage

// File: rtl/hamming_nibble_fifo.sv
// Purpose : First-word-fall-through FIFO for decoded nibbles. The head
//           entry is visible combinationally on o_rdata. A push while full
//           is still accepted when a pop happens in the same cycle.
// Ports   : clk, rst_n  - clock, async active-low reset
//           i_en        - global enable, all state holds when low
//           i_push      - write request, i_wdata - write data
//           i_pop       - consumer ready (pop taken only when non-empty)
//           o_rdata     - head entry, o_valid - FIFO non-empty
//           o_drop      - pulse: push rejected because FIFO full
module hamming_nibble_fifo
    import hamming_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_valid,
    output logic             o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    // The extra pointer MSB separates full (MSBs differ) from empty (equal)
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_en && i_pop && !w_empty;
    // When full, a same-cycle pop frees the head slot the write lands in
    assign w_push  = i_en && i_push && (!w_full || w_pop);
    assign o_drop  = i_en && i_push && w_full && !w_pop;

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_valid = !w_empty;

    // Pointer update; wraps naturally modulo 2*DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Storage write; cleared on reset so the head reads zero when empty after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/uart_hamming_decoder.sv
// Purpose : Two-stage Hamming(7,4) decoder behind the UART receiver.
//           Stage 1 latches the codeword and its syndrome, stage 2
//           corrects a single-bit error, extracts the nibble and pushes
//           {corr, nibble} into a FWFT FIFO drained by valid/ready.
// Ports   : clk, rst_n        - clock, async active-low reset
//           ena               - global enable (everything freezes when low)
//           cw_in, cw_valid   - codeword and one-cycle strobe
//           data_out,corr_out - FIFO head nibble and its corrected flag
//           data_valid        - FIFO non-empty
//           data_ready        - consumer accepts the head
//           overflow          - sticky word-dropped flag
//           corr_count        - saturating count of corrected words
module uart_hamming_decoder
    import hamming_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [6:0]       cw_in,
    input  logic             cw_valid,
    output logic [3:0]       data_out,
    output logic             corr_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] corr_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [6:0]       r_cw_q;
    logic [2:0]       r_syn_q;
    logic             r_v1;
    logic             r_overflow;
    logic [CNT_W-1:0] r_corr_count;

    logic [6:0]       w_fixed;
    logic             w_corr;
    logic             w_push;
    logic             w_drop;
    logic [4:0]       w_head;

    // Stage 1: capture codeword and syndrome on a strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_cw_q  <= 7'd0;
            r_syn_q <= 3'd0;
        end else if (ena) begin
            r_v1 <= cw_valid;
            if (cw_valid) begin
                r_cw_q  <= cw_in;
                r_syn_q <= hamming_syndrome(cw_in);
            end
        end
    end

    // Stage 2: correction; parity-bit errors still count as corrected
    assign w_fixed = hamming_correct(r_cw_q, r_syn_q);
    assign w_corr  = (r_syn_q != 3'd0);
    assign w_push  = r_v1 && ena;

    hamming_nibble_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (5)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (ena),
        .i_push  (w_push),
        .i_wdata ({w_corr, hamming_extract(w_fixed)}),
        .i_pop   (data_ready),
        .o_rdata (w_head),
        .o_valid (data_valid),
        .o_drop  (w_drop)
    );

    // Sticky overflow, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Correction counter; counts every corrected word even if the FIFO drops it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_count <= '0;
        end else if (w_push && w_corr && (r_corr_count != CNT_MAX)) begin
            r_corr_count <= r_corr_count + CNT_W'(1);
        end
    end

    assign data_out   = w_head[3:0];
    assign corr_out   = w_head[4];
    assign overflow   = r_overflow;
    assign corr_count = r_corr_count;

endmodule

// File: tb/tb_uart_hamming_decoder.sv
module tb_uart_hamming_decoder;
    import hamming_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [6:0] cw_in;
    logic       cw_valid;
    logic [3:0] data_out;
    logic       corr_out;
    logic       data_valid;
    logic       data_ready;
    logic       overflow;
    logic [7:0] corr_count;

    // Second instance with a 2-bit counter for the saturation scenario
    logic [6:0] sat_cw;
    logic       sat_valid;
    logic       sat_ready;
    logic [3:0] sat_data;
    logic       sat_corr;
    logic       sat_dv;
    logic       sat_ovf;
    logic [1:0] sat_count;

    int checks = 0;
    int errors = 0;

    uart_hamming_decoder #(.DEPTH(4), .CNT_W(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cw_in      (cw_in),
        .cw_valid   (cw_valid),
        .data_out   (data_out),
        .corr_out   (corr_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overflow   (overflow),
        .corr_count (corr_count)
    );

    uart_hamming_decoder #(.DEPTH(4), .CNT_W(2)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cw_in      (sat_cw),
        .cw_valid   (sat_valid),
        .data_out   (sat_data),
        .corr_out   (sat_corr),
        .data_valid (sat_dv),
        .data_ready (sat_ready),
        .overflow   (sat_ovf),
        .corr_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe of a codeword; returns one cycle after the strobe edge
    task automatic send(input logic [6:0] cw);
        cw_in    = cw;
        cw_valid = 1'b1;
        tick();
        cw_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", data_valid); end
        checks++;
        if (data_out !== 4'h0 || corr_out !== 1'b0) begin errors++; $display("FAIL reset_head: got %h/%b expected 0/0", data_out, corr_out); end
        checks++;
        if (overflow !== 1'b0 || corr_count !== 8'd0) begin errors++; $display("FAIL reset_flags: got ovf %b cnt %0d expected 0/0", overflow, corr_count); end
        rst_n = 1'b1;
        tick();
    endtask

    // Two clean words back-to-back with continuous consumer
    task automatic test_clean;
        data_ready = 1'b1;
        send(7'h55);
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL clean_latency_n1: got dv %b expected 0", data_valid); end
        send(7'h07);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 4'hB || corr_out !== 1'b0) begin
            errors++; $display("FAIL clean_first: got dv %b data %h corr %b expected 1 b 0", data_valid, data_out, corr_out);
        end
        tick();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 4'h1 || corr_out !== 1'b0) begin
            errors++; $display("FAIL clean_second: got dv %b data %h corr %b expected 1 1 0", data_valid, data_out, corr_out);
        end
        tick();
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL clean_drained: got dv %b expected 0", data_valid); end
        checks++;
        if (corr_count !== 8'd0) begin errors++; $display("FAIL clean_count: got %0d expected 0", corr_count); end
    endtask

    task automatic test_single_error;
        data_ready = 1'b1;
        send(7'h45);
        tick();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 4'hB || corr_out !== 1'b1) begin
            errors++; $display("FAIL single_0x45: got dv %b data %h corr %b expected 1 b 1", data_valid, data_out, corr_out);
        end
        checks++;
        if (corr_count !== 8'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", corr_count); end
        // Sweep every nibble with every single-bit flip
        for (int n = 0; n < 16; n++) begin
            for (int b = 0; b < 7; b++) begin
                logic [6:0] cw;
                logic [3:0] exp_n;
                exp_n = 4'(n);
                cw = hamming_encode(exp_n) ^ (7'd1 << b);
                send(cw);
                tick();
                checks++;
                if (data_valid !== 1'b1 || data_out !== exp_n || corr_out !== 1'b1) begin
                    errors++; $display("FAIL sweep n=%0d b=%0d: got dv %b data %h corr %b expected 1 %h 1", n, b, data_valid, data_out, corr_out, exp_n);
                end
            end
        end
        tick();
        checks++;
        if (corr_count !== 8'd113) begin errors++; $display("FAIL sweep_count: got %0d expected 113", corr_count); end
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL sweep_drained: got dv %b expected 0", data_valid); end
    endtask

    task automatic test_full_overflow;
        logic [3:0] exp_q [4];
        data_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(hamming_encode(4'(i)));
        end
        tick();
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow: got %b expected 1", overflow); end
        checks++;
        if (data_valid !== 1'b1 || data_out !== 4'h1) begin errors++; $display("FAIL full_head: got dv %b data %h expected 1 1", data_valid, data_out); end
        // Push nibble 6 in the same cycle the head is popped
        send(hamming_encode(4'h6));
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        tick();
        exp_q[0] = 4'h2; exp_q[1] = 4'h3; exp_q[2] = 4'h4; exp_q[3] = 4'h6;
        data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_valid !== 1'b1 || data_out !== exp_q[i] || corr_out !== 1'b0) begin
                errors++; $display("FAIL full_drain[%0d]: got dv %b data %h corr %b expected 1 %h 0", i, data_valid, data_out, corr_out, exp_q[i]);
            end
            tick();
        end
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got dv %b expected 0", data_valid); end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 5; i++) begin
            sat_cw    = hamming_encode(4'(i)) ^ 7'h01;
            sat_valid = 1'b1;
            tick();
        end
        sat_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (sat_count !== 2'd3) begin errors++; $display("FAIL saturation: got %0d expected 3", sat_count); end
    endtask

    task automatic test_ena_gating;
        data_ready = 1'b0;
        send(hamming_encode(4'hA));
        send(hamming_encode(4'hC));
        tick();
        tick();
        ena        = 1'b0;
        data_ready = 1'b1;
        send(hamming_encode(4'h3));
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (data_valid !== 1'b1 || data_out !== 4'hA || corr_out !== 1'b0) begin
                errors++; $display("FAIL ena_hold[%0d]: got dv %b data %h expected 1 a", i, data_valid, data_out);
            end
            tick();
        end
        ena = 1'b1;
        checks++;
        if (data_out !== 4'hA) begin errors++; $display("FAIL ena_resume_a: got %h expected a", data_out); end
        tick();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 4'hC) begin errors++; $display("FAIL ena_resume_c: got dv %b data %h expected 1 c", data_valid, data_out); end
        tick();
        tick();
        tick();
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL ena_lost_strobe: got dv %b expected 0", data_valid); end
    endtask

    task automatic test_reset_midstream;
        data_ready = 1'b0;
        send(hamming_encode(4'h7));
        send(hamming_encode(4'h8));
        send(hamming_encode(4'h9));
        send(hamming_encode(4'hA));
        checks++;
        if (data_valid !== 1'b1 || data_out !== 4'h7) begin errors++; $display("FAIL mid_queued: got dv %b data %h expected 1 7", data_valid, data_out); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (data_valid !== 1'b0 || data_out !== 4'h0) begin errors++; $display("FAIL mid_reset_dv: got dv %b data %h expected 0 0", data_valid, data_out); end
        checks++;
        if (overflow !== 1'b0 || corr_count !== 8'd0) begin errors++; $display("FAIL mid_reset_flags: got ovf %b cnt %0d expected 0 0", overflow, corr_count); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL mid_stage1_cleared: got dv %b expected 0", data_valid); end
        data_ready = 1'b1;
        send(hamming_encode(4'h6));
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL mid_latency_n1: got dv %b expected 0", data_valid); end
        tick();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 4'h6 || corr_out !== 1'b0) begin
            errors++; $display("FAIL mid_after_reset: got dv %b data %h corr %b expected 1 6 0", data_valid, data_out, corr_out);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        cw_in      = 7'd0;
        cw_valid   = 1'b0;
        data_ready = 1'b0;
        sat_cw     = 7'd0;
        sat_valid  = 1'b0;
        sat_ready  = 1'b1;
        test_reset();
        test_clean();
        test_single_error();
        test_full_overflow();
        test_saturation();
        test_ena_gating();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
